// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word and RAM status types, plus the memory
// arbiter's state encoding, default requester count and a small helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Two ports per core: even index is the instruction port, odd is data.
    localparam int ARB_NREQ_DEFAULT = 4;

    // Core index following cur, wrapping after n-1.
    function automatic int next_core(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: returns the first asserted request at or after the
// pointer, scanning upward with wrap-around.
module rr_select #(
    parameter int N = 2
) (
    input  logic [N-1:0]                   req_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
    output logic                           valid_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: grants one of NREQ requesters (I/D ports of NREQ/2 cores)
// access to a single RAM. Data ports beat instruction ports; within a class
// cores are served round-robin. The owner's request is registered at grant
// and held until completion, abort, error or reset.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = ARB_NREQ_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NREQ-1:0]   ren,
    input  logic [NREQ-1:0]   wen,
    input  word_t [NREQ-1:0]  addr,
    input  word_t [NREQ-1:0]  store,
    output logic [NREQ-1:0]   mwait,
    output word_t             load,
    output logic              ramREN,
    output logic              ramWEN,
    output word_t             ramaddr,
    output word_t             ramstore,
    input  word_t             ramload,
    input  ramstate_t         ramstate
);
    localparam int NCORE = NREQ / 2;
    localparam int PW    = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int OW    = $clog2(NREQ);

    logic [NREQ-1:0]  active;
    logic [NCORE-1:0] i_req, d_req;
    logic             i_valid, d_valid;
    logic [PW-1:0]    i_idx, d_idx;
    logic [OW-1:0]    win_idx;

    arb_state_t    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    word_t         addr_q, addr_d;
    word_t         store_q, store_d;
    logic          dir_q, dir_d;          // 1 = write
    logic [PW-1:0] iptr_q, iptr_d;
    logic [PW-1:0] dptr_q, dptr_d;

    logic          owner_active;
    logic          complete;
    logic [PW-1:0] owner_core;

    // A write request takes precedence when both enables are set.
    assign active = ren | wen;

    // Split requests into instruction and data classes, indexed by core.
    always_comb begin
        i_req = '0;
        d_req = '0;
        for (int k = 0; k < NCORE; k++) begin
            i_req[k] = active[2*k];
            d_req[k] = active[2*k+1];
        end
    end

    rr_select #(.N(NCORE)) u_sel_i (
        .req_i   (i_req),
        .ptr_i   (iptr_q),
        .valid_o (i_valid),
        .idx_o   (i_idx)
    );

    rr_select #(.N(NCORE)) u_sel_d (
        .req_i   (d_req),
        .ptr_i   (dptr_q),
        .valid_o (d_valid),
        .idx_o   (d_idx)
    );

    assign win_idx      = d_valid ? OW'(2 * int'(d_idx) + 1) : OW'(2 * int'(i_idx));
    assign owner_active = active[owner_q];
    assign owner_core   = PW'(owner_q >> 1);
    assign complete     = (state_q == SERVE) && owner_active && (ramstate == ACCESS);
    assign load         = ramload;

    // State and owner registers; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            store_q <= '0;
            dir_q   <= 1'b0;
            iptr_q  <= '0;
            dptr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            dir_q   <= dir_d;
            iptr_q  <= iptr_d;
            dptr_q  <= dptr_d;
        end
    end

    // Next state: grant from IDLE; leave SERVE on abort, completion or error.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        store_d = store_q;
        dir_d   = dir_q;
        iptr_d  = iptr_q;
        dptr_d  = dptr_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_d = SERVE;
                    owner_d = win_idx;
                    addr_d  = addr[win_idx];
                    store_d = store[win_idx];
                    dir_d   = wen[win_idx];
                end
            end
            SERVE: begin
                if (!owner_active) begin
                    // Owner withdrew: abort without moving the pointer.
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (owner_q[0]) dptr_d = PW'(next_core(int'(owner_core), NCORE));
                    else            iptr_d = PW'(next_core(int'(owner_core), NCORE));
                end else if (ramstate == ERROR) begin
                    // Failed access: drop the grant, request is re-arbitrated.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RAM side from registered owner fields, stall per requester.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == SERVE) begin
            ramREN   = !dir_q;
            ramWEN   = dir_q;
            ramaddr  = addr_q;
            ramstore = store_q;
        end
        mwait = active;
        if (complete) mwait[owner_q] = 1'b0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ  = 4;
    localparam int NCORE = NREQ / 2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [NREQ-1:0]  ren, wen;
    word_t [NREQ-1:0] addr, store;
    logic [NREQ-1:0]  mwait;
    word_t            load;
    logic             ramREN, ramWEN;
    word_t            ramaddr, ramstore, ramload;
    ramstate_t        ramstate;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.NREQ(NREQ)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ren      (ren),
        .wen      (wen),
        .addr     (addr),
        .store    (store),
        .mwait    (mwait),
        .load     (load),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    // Port i presents address base+i and write data st+i.
    task automatic set_ports(input word_t base, input word_t st);
        for (int i = 0; i < NREQ; i++) begin
            addr[i]  = base + word_t'(i);
            store[i] = st + word_t'(i);
        end
    endtask

    task automatic do_reset();
        next_cycle();
        nRST = 1'b0;
        ren = '0; wen = '0; ramstate = FREE; ramload = '0;
        next_cycle();
        nRST = 1'b1;
    endtask

    typedef struct {
        logic [3:0] ren, wen;
        word_t      base, st;
        ramstate_t  rs;
        word_t      rl;
        logic       e_ren, e_wen;
        word_t      e_addr, e_store;
        logic [3:0] e_mwait;
    } vec_t;

    vec_t vecs[10];

    // Behavioural model state
    bit         m_serving;
    int         m_owner;
    word_t      m_addr, m_store;
    bit         m_write;
    int         m_ptr[2];          // [0] instruction class, [1] data class
    logic [3:0] comp_prev;

    int got[$];
    int exp_rr[4] = '{1, 3, 1, 3};

    initial begin
        // Single read with two BUSY cycles, then I vs D contention.
        vecs[0] = '{4'b0010, 4'b0000, 32'h3F,  32'h1000, FREE,   32'h0,        0, 0, 32'h0,   32'h0,    4'b0010};
        vecs[1] = '{4'b0010, 4'b0000, 32'h3F,  32'h1000, BUSY,   32'h0,        1, 0, 32'h40,  32'h1001, 4'b0010};
        vecs[2] = '{4'b0010, 4'b0000, 32'h3F,  32'h1000, BUSY,   32'h0,        1, 0, 32'h40,  32'h1001, 4'b0010};
        vecs[3] = '{4'b0010, 4'b0000, 32'h3F,  32'h1000, ACCESS, 32'hDEADBEEF, 1, 0, 32'h40,  32'h1001, 4'b0000};
        vecs[4] = '{4'b0000, 4'b0000, 32'h3F,  32'h1000, FREE,   32'h0,        0, 0, 32'h0,   32'h0,    4'b0000};
        vecs[5] = '{4'b0001, 4'b0010, 32'h100, 32'h1233, FREE,   32'h0,        0, 0, 32'h0,   32'h0,    4'b0011};
        vecs[6] = '{4'b0001, 4'b0010, 32'h100, 32'h1233, ACCESS, 32'h5555,     0, 1, 32'h101, 32'h1234, 4'b0001};
        vecs[7] = '{4'b0001, 4'b0000, 32'h100, 32'h1233, FREE,   32'h0,        0, 0, 32'h0,   32'h0,    4'b0001};
        vecs[8] = '{4'b0001, 4'b0000, 32'h100, 32'h1233, ACCESS, 32'h77,       1, 0, 32'h100, 32'h1233, 4'b0000};
        vecs[9] = '{4'b0000, 4'b0000, 32'h100, 32'h1233, FREE,   32'h0,        0, 0, 32'h0,   32'h0,    4'b0000};

        nRST = 1'b0;
        ren = '0; wen = '0; ramstate = FREE; ramload = '0;
        set_ports(32'h0, 32'h0);

        // Reset state
        settle();
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_mwait_idle", mwait, 0);
        ren[2] = 1'b1;
        #1;
        check("rst_mwait_active", mwait, 4'b0100);
        ren = '0;
        next_cycle();
        nRST = 1'b1;

        // Directed vector table
        for (int r = 0; r < 10; r++) begin
            ren = vecs[r].ren; wen = vecs[r].wen;
            ramstate = vecs[r].rs; ramload = vecs[r].rl;
            set_ports(vecs[r].base, vecs[r].st);
            settle();
            check($sformatf("vec%0d_ramREN", r), ramREN, vecs[r].e_ren);
            check($sformatf("vec%0d_ramWEN", r), ramWEN, vecs[r].e_wen);
            check($sformatf("vec%0d_ramaddr", r), ramaddr, vecs[r].e_addr);
            check($sformatf("vec%0d_ramstore", r), ramstore, vecs[r].e_store);
            check($sformatf("vec%0d_mwait", r), mwait, vecs[r].e_mwait);
            check($sformatf("vec%0d_load", r), load, vecs[r].rl);
            next_cycle();
        end

        // Round robin between data ports 1 and 3, held continuously
        do_reset();
        set_ports(32'h200, 32'h0);
        ramstate = ACCESS;
        ren = 4'b1010;
        for (int c = 0; c < 16 && got.size() < 4; c++) begin
            settle();
            if (ramREN) begin
                check($sformatf("rr_grant%0d_addr", got.size()), ramaddr, 32'h200 + exp_rr[got.size()]);
                check($sformatf("rr_grant%0d_mwait", got.size()), mwait,
                      4'b1010 & ~(4'b0001 << exp_rr[got.size()]));
                got.push_back(int'(ramaddr));
            end
            next_cycle();
        end
        check("rr_grant_count", got.size(), 4);
        ren = '0;

        // Move data pointer to core 1 with one completion of port 1
        ren = 4'b0010;
        settle();
        next_cycle();
        settle();
        check("pre_abort_addr", ramaddr, 32'h201);
        check("pre_abort_mwait", mwait, 4'b0000);
        next_cycle();
        ren = '0;

        // Abort: port 3 drops during BUSY
        ren = 4'b1000; ramstate = BUSY;
        settle();
        next_cycle();
        settle();
        check("abort_serve_ren", ramREN, 1);
        check("abort_serve_addr", ramaddr, 32'h203);
        check("abort_serve_mwait", mwait, 4'b1000);
        next_cycle();
        ren = '0;
        settle();
        check("abort_drop_mwait", mwait, 4'b0000);
        next_cycle();
        settle();
        check("abort_ren_low", ramREN, 0);
        // Pointer must still favour core 1: port 3 wins over port 1
        ren = 4'b1010; ramstate = ACCESS;
        next_cycle();
        settle();
        check("abort_ptr_kept_ren", ramREN, 1);
        check("abort_ptr_kept_addr", ramaddr, 32'h203);
        next_cycle();
        ren = '0;
        settle();
        next_cycle();

        // ERROR on first access to 0x80, retried and completed
        set_ports(32'h7F, 32'h0);
        ren = 4'b0010; ramstate = ERROR;
        settle();
        next_cycle();
        settle();
        check("err_first_ren", ramREN, 1);
        check("err_first_addr", ramaddr, 32'h80);
        check("err_first_mwait", mwait, 4'b0010);
        next_cycle();
        settle();
        check("err_idle_ren", ramREN, 0);
        check("err_idle_mwait", mwait, 4'b0010);
        next_cycle();
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        settle();
        check("err_retry_addr", ramaddr, 32'h80);
        check("err_retry_mwait", mwait, 4'b0000);
        check("err_retry_load", load, 32'hCAFEF00D);
        next_cycle();
        ren = '0;

        // Reset in the middle of a write
        set_ports(32'h300, 32'hA000);
        wen = 4'b1000; ramstate = BUSY;
        settle();
        next_cycle();
        settle();
        check("rstmid_wen_before", ramWEN, 1);
        check("rstmid_store_before", ramstore, 32'hA003);
        #1 nRST = 1'b0;
        #1;
        check("rstmid_wen", ramWEN, 0);
        check("rstmid_ren", ramREN, 0);
        check("rstmid_addr", ramaddr, 0);
        check("rstmid_store", ramstore, 0);
        check("rstmid_mwait", mwait, 4'b1000);
        next_cycle();
        nRST = 1'b1; ramstate = ACCESS;
        settle();
        check("rstmid_idle_wen", ramWEN, 0);
        check("rstmid_idle_mwait", mwait, 4'b1000);
        next_cycle();
        settle();
        check("rstmid_regrant_wen", ramWEN, 1);
        check("rstmid_regrant_mwait", mwait, 4'b0000);
        next_cycle();
        wen = '0;

        // Random traffic against the behavioural model
        do_reset();
        m_serving = 0; m_owner = 0; m_addr = '0; m_store = '0; m_write = 0;
        m_ptr[0] = 0; m_ptr[1] = 0;
        comp_prev = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] act;
            logic       comp;
            int         pick;
            int         r;
            // Stimulus: hold requests until completion, occasional aborts
            for (int i = 0; i < NREQ; i++) begin
                if (ren[i] || wen[i]) begin
                    if (comp_prev[i] || $urandom_range(0, 99) < 3) begin
                        ren[i] = 1'b0; wen[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 30) begin
                    if (i % 2 == 0) begin
                        ren[i] = 1'b1; wen[i] = 1'b0;
                    end else begin
                        wen[i] = 1'($urandom_range(0, 1));
                        ren[i] = wen[i] ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                end
                addr[i]  = $urandom;
                store[i] = $urandom;
            end
            r = $urandom_range(0, 9);
            if (r < 5)       ramstate = BUSY;
            else if (r < 8)  ramstate = ACCESS;
            else if (r == 8) ramstate = ERROR;
            else             ramstate = FREE;
            ramload = $urandom;

            settle();
            act  = ren | wen;
            comp = m_serving && act[m_owner] && (ramstate == ACCESS);
            check("rnd_ramREN", ramREN, m_serving && !m_write);
            check("rnd_ramWEN", ramWEN, m_serving && m_write);
            check("rnd_ramaddr", ramaddr, m_serving ? m_addr : 32'h0);
            check("rnd_ramstore", ramstore, m_serving ? m_store : 32'h0);
            check("rnd_mwait", mwait, act & ~(comp ? (4'b0001 << m_owner) : 4'b0000));
            check("rnd_load", load, ramload);
            comp_prev = comp ? (4'b0001 << m_owner) : 4'b0000;

            // Model transition for the coming edge
            if (!m_serving) begin
                if (act != 0) begin
                    int cls;
                    cls  = (act[1] || act[3]) ? 1 : 0;
                    pick = -1;
                    for (int k = NCORE - 1; k >= 0; k--) begin
                        int core;
                        core = (m_ptr[cls] + k) % NCORE;
                        if (act[2*core + cls]) pick = 2*core + cls;
                    end
                    m_owner   = pick;
                    m_addr    = addr[pick];
                    m_store   = store[pick];
                    m_write   = wen[pick];
                    m_serving = 1;
                end
            end else if (!act[m_owner]) begin
                m_serving = 0;
            end else if (ramstate == ACCESS) begin
                m_serving = 0;
                m_ptr[m_owner % 2] = (m_owner / 2 + 1) % NCORE;
            end else if (ramstate == ERROR) begin
                m_serving = 0;
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; index 2k is core k instruction port, index 2k+1 is core k data port.
REQ-002 CLK  input  1  system clock; all state on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 ren  input  NREQ  per-requester read request.
REQ-005 wen  input  NREQ  per-requester write request; instruction ports tie low.
REQ-006 addr  input  NREQ x 32  per-requester word address.
REQ-007 store  input  NREQ x 32  per-requester write data.
REQ-008 mwait  output  NREQ  per-requester stall; low only in the completing cycle of that requester's access.
REQ-009 load  output  32  ramload broadcast to all requesters.
REQ-010 ramREN, ramWEN  output  1 each  RAM enables.
REQ-011 ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-012 ramload  input  32  RAM read data.
REQ-013 ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-014 Requester i is active when ren[i] or wen[i]; both set is a write.
REQ-015 mwait[i] SHALL be high whenever requester i is active and not completing; low when inactive.
REQ-016 FSM states IDLE and SERVE; IDLE with any active requester selects a winner and moves to SERVE next edge, registering owner index, address, data, direction.
REQ-017 Selection: data ports beat instruction ports; ties within a class resolved round-robin by core via a registered pointer.
REQ-018 Round-robin pointer advances to the core after the winner only on completion, per class (separate pointers for I and D).
REQ-019 In SERVE, ramREN/ramWEN/ramaddr/ramstore driven from registered owner fields; all RAM outputs zero in IDLE.
REQ-020 Completion: SERVE with ramstate==ACCESS; mwait[owner] low that same cycle (combinational), FSM returns to IDLE next edge.
REQ-021 Minimum latency: request at cycle 0, RAM enables at cycle 1, earliest mwait low at cycle 1 if RAM returns ACCESS immediately; back-to-back grants separated by one IDLE cycle.
REQ-022 Owner drops its request while in SERVE: abort, RAM enables deassert next edge, return to IDLE, pointer not advanced.
REQ-023 ramstate==ERROR in SERVE: return to IDLE without completion, mwait stays high, request re-arbitrated.
REQ-024 Owner changes addr/store mid-access: ignored; registered values used until completion.
REQ-025 load SHALL equal ramload at all times; only owner samples it.

Reset
REQ-026 nRST low: FSM IDLE, owner 0, both pointers 0, registered addr/data/direction 0; all RAM outputs 0; mwait follows REQ-015.
REQ-027 Reset mid-access abandons the access with no completion signalled.

Structure
REQ-028 word_t and ramstate_t come from cpu_types_pkg; arbiter state enum and NREQ default added there.
REQ-029 One sub-module, rr_select: NREQ/2-wide round-robin picker, reused for I and D classes.

Verification
REQ-030 Single read: ren[1]=1 addr=0x40, RAM ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> mwait[1] low in cycle 3, load=0xDEADBEEF, FSM IDLE cycle 4.
REQ-031 I vs D contention: ren[0] and wen[1] same cycle -> port 1 served first with ramWEN=1, port 0 next grant.
REQ-032 Round robin: ren[1] and ren[3] held continuously -> grants alternate 1,3,1,3 over four completions.
REQ-033 Abort: ren[3] dropped during BUSY -> ramREN low next cycle, no mwait-low pulse, pointer unchanged.
REQ-034 ERROR: ramstate=ERROR on first access to 0x80 -> retried, second attempt ACCESS completes with correct load.
REQ-035 Reset during SERVE: nRST low mid-write -> outputs zero immediately, FSM IDLE, ramWEN 0.
